// File: rtl/shift_register_sequencer_if.sv
// -----------------------------------------------------------------------------
// shift_register_sequencer_if
//   Word-level handshakes of the shift-register sequencer.
//   tx side : tx_valid / tx_ready / tx_data  (words to serialise into the chain)
//   rx side : rx_valid / rx_ready / rx_data  (words reassembled from the chain)
//   modport master : the word producer/consumer (drives tx_valid, tx_data, rx_ready)
//   modport slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface shift_register_sequencer_if #(
    parameter int W = 8
);
    logic         tx_valid;
    logic         tx_ready;
    logic [W-1:0] tx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [W-1:0] rx_data;

    modport master (
        output tx_valid, tx_data, rx_ready,
        input  tx_ready, rx_valid, rx_data
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready,
        output tx_ready, rx_valid, rx_data
    );
endinterface

// File: rtl/shift_register_sequencer.sv
// -----------------------------------------------------------------------------
// shift_register_sequencer
//   Sequences an external enable-gated SISO shift-register chain of DEPTH
//   stages. A word accepted on the tx handshake is driven LSB-first onto sin
//   for W cycles, followed by DEPTH zero-fill cycles. The chain output sout is
//   captured during the last W of those W+DEPTH shift cycles, and the
//   reassembled word is presented on the rx handshake.
//
// Parameters : W     - word width (>=1)
//              DEPTH - stages in the sequenced chain (>=1)
// Ports      : clk      - rising-edge clock shared with the chain
//              clear    - synchronous active-high reset
//              bus      - tx/rx word handshakes (slave modport)
//              sin      - serial bit into chain stage 0
//              shift_en - chain shifts on this clk edge when high
//              sout     - serial output of the last chain stage
//              busy     - high while shifting or holding a captured word
//              err      - (SHIFT_REGISTER_SEQUENCER_CHECK_EN only) captured
//                         word differs from the transmitted word; valid with
//                         rx_valid
// Build option: define SHIFT_REGISTER_SEQUENCER_CHECK_EN to add the err
//               output and its loopback comparator.
// -----------------------------------------------------------------------------
module shift_register_sequencer #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          clear,
    shift_register_sequencer_if.slave     bus,
    output logic                          sin,
    output logic                          shift_en,
    input  logic                          sout,
`ifdef SHIFT_REGISTER_SEQUENCER_CHECK_EN
    output logic                          busy,
    output logic                          err
`else
    output logic                          busy
`endif
);
    localparam int              CW     = $clog2(W + DEPTH + 1);
    localparam logic [CW-1:0]   LAST_C = CW'(W + DEPTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [W-1:0]  shadow_reg;
    logic [W-1:0]  rx_data_reg;

    // Per-bit one-hot helpers: bit_sel picks the shadow bit for this shift
    // cycle (all zero once cnt passes W, giving the zero fill), cap_hit marks
    // the rx bit that sout belongs to in this shift cycle.
    logic [W-1:0]  bit_sel;
    logic [W-1:0]  cap_hit;

    for (genvar gi = 0; gi < W; gi++) begin : g_bits
        assign bit_sel[gi] = shadow_reg[gi] & (cnt_reg == CW'(gi));
        assign cap_hit[gi] = (state_reg == SHIFT) & (cnt_reg == CW'(gi + DEPTH));
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.tx_valid)         state_next = SHIFT;
            SHIFT:   if (cnt_reg == LAST_C)    state_next = DONE;
            DONE:    if (bus.rx_ready)         state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            shadow_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && bus.tx_valid) begin
                shadow_reg <= bus.tx_data;
                cnt_reg    <= '0;
            end else if (state_reg == SHIFT) begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    // Only cycles c >= DEPTH are sampled, so whatever the chain held before
    // this word never reaches rx_data.
    always_ff @(posedge clk) begin
        if (clear) begin
            rx_data_reg <= '0;
        end else begin
            rx_data_reg <= (rx_data_reg & ~cap_hit) | (cap_hit & {W{sout}});
        end
    end

`ifdef SHIFT_REGISTER_SEQUENCER_CHECK_EN
    // The last bit lands in rx_data on the same edge that enters DONE, so the
    // comparison uses sout directly for bit W-1.
    logic [W-1:0] final_word;
    logic         err_reg;

    always_comb begin
        final_word        = rx_data_reg;
        final_word[W-1]   = sout;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            err_reg <= 1'b0;
        end else if (state_reg == SHIFT && cnt_reg == LAST_C) begin
            err_reg <= (final_word != shadow_reg);
        end else if (state_reg == DONE && bus.rx_ready) begin
            err_reg <= 1'b0;
        end
    end

    assign err = err_reg;
`endif

    assign sin          = (state_reg == SHIFT) & (|bit_sel);
    assign shift_en     = (state_reg == SHIFT);
    assign bus.tx_ready = (state_reg == IDLE);
    assign bus.rx_valid = (state_reg == DONE);
    assign bus.rx_data  = rx_data_reg;
    assign busy         = (state_reg == SHIFT) | (state_reg == DONE);

endmodule

// File: tb/tb_shift_register_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_register_sequencer
//   Directed bench: a W=8/DEPTH=4 sequencer around an ideal 4-stage chain
//   model (with a one-shot fault on stage 2), plus a W=1/DEPTH=1 instance
//   around a single-stage chain.
// -----------------------------------------------------------------------------
module tb_shift_register_sequencer;
    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    // ---------------- W=8, DEPTH=4 instance ----------------
    shift_register_sequencer_if #(.W(8)) bus ();
    logic sin, shift_en, sout, busy;
    logic flip;
    logic [3:0] chain = 4'hF;   // stale ones in the chain at start

    always @(posedge clk) begin
        if (shift_en) begin
            chain <= {chain[2:0], sin};
            if (flip) chain[2] <= ~chain[1];
        end
    end
    assign sout = chain[3];

    // ---------------- W=1, DEPTH=1 instance ----------------
    shift_register_sequencer_if #(.W(1)) bus1 ();
    logic sin1, shift_en1, sout1, busy1;
    logic chain1 = 1'b0;

    always @(posedge clk) if (shift_en1) chain1 <= sin1;
    assign sout1 = chain1;

`ifdef SHIFT_REGISTER_SEQUENCER_CHECK_EN
    logic err, err1;
    shift_register_sequencer #(.W(8), .DEPTH(4)) dut (
        .clk(clk), .clear(clear), .bus(bus), .sin(sin), .shift_en(shift_en),
        .sout(sout), .busy(busy), .err(err)
    );
    shift_register_sequencer #(.W(1), .DEPTH(1)) dut1 (
        .clk(clk), .clear(clear), .bus(bus1), .sin(sin1), .shift_en(shift_en1),
        .sout(sout1), .busy(busy1), .err(err1)
    );
`else
    shift_register_sequencer #(.W(8), .DEPTH(4)) dut (
        .clk(clk), .clear(clear), .bus(bus), .sin(sin), .shift_en(shift_en),
        .sout(sout), .busy(busy)
    );
    shift_register_sequencer #(.W(1), .DEPTH(1)) dut1 (
        .clk(clk), .clear(clear), .bus(bus1), .sin(sin1), .shift_en(shift_en1),
        .sout(sout1), .busy(busy1)
    );
`endif

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word, then follow it until rx_valid. lat is the index of the
    // first rx_valid cycle, counting the cycle after the accept edge as 1.
    task automatic send_word(input logic [7:0] d, input int flip_cyc,
                             output logic [11:0] sin_seq, output int en_cnt,
                             output int lat);
        int waitc = 0;
        while (!bus.tx_ready && waitc < 50) begin
            tick();
            waitc++;
        end
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        tick();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
        sin_seq = '0;
        en_cnt  = 0;
        lat     = 1;
        while (!bus.rx_valid && lat < 100) begin
            if (lat <= 12) sin_seq[lat-1] = sin;
            en_cnt += int'(shift_en);
            flip = (lat - 1 == flip_cyc);
            tick();
            flip = 1'b0;
            lat++;
        end
        $display("tx %02h -> rx %02h (rx_valid in cycle %0d)", d, bus.rx_data, lat);
    endtask

    task automatic take_word();
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
    endtask

    logic [11:0] sseq;
    int          en, lat, n_acc, n_rx;
    logic [7:0]  got [2];

    initial begin
        clear = 1'b1;
        flip  = 1'b0;
        bus.tx_valid  = 1'b0; bus.tx_data  = '0; bus.rx_ready  = 1'b0;
        bus1.tx_valid = 1'b0; bus1.tx_data = '0; bus1.rx_ready = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_tx_ready", bus.tx_ready, 1);
        check("rst_sin",      sin,          0);
        check("rst_shift_en", shift_en,     0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_data",  bus.rx_data,  0);
        check("rst_busy",     busy,         0);
        check("rst1_tx_ready", bus1.tx_ready, 1);
        check("rst1_rx_data",  bus1.rx_data,  0);
`ifdef SHIFT_REGISTER_SEQUENCER_CHECK_EN
        check("rst_err", err, 0);
`endif
        clear = 1'b0;
        tick();

        // 0xA5: sin LSB-first then 4 zeros = 12'h0A5, 12 shift cycles,
        // rx_valid in the 13th cycle after the accept edge
        send_word(8'hA5, -1, sseq, en, lat);
        check("a5_sin_seq",  sseq,         12'h0A5);
        check("a5_shift_en", en,           12);
        check("a5_latency",  lat,          13);
        check("a5_rx_valid", bus.rx_valid, 1);
        check("a5_rx_data",  bus.rx_data,  8'hA5);
        check("a5_busy",     busy,         1);
        check("a5_done_sin", sin,          0);

        // Back-pressure: DONE holds for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_rx_valid", bus.rx_valid, 1);
            check("hold_rx_data",  bus.rx_data,  8'hA5);
            check("hold_shift_en", shift_en,     0);
            check("hold_tx_ready", bus.tx_ready, 0);
        end
        take_word();
        check("rel_tx_ready", bus.tx_ready, 1);
        check("rel_rx_valid", bus.rx_valid, 0);
        check("rel_busy",     busy,         0);

        // Back-to-back 0xFF then 0x00 with tx_valid held high
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        bus.rx_ready = 1'b1;
        n_acc = 0;
        n_rx  = 0;
        for (int cyc = 0; cyc < 80 && n_rx < 2; cyc++) begin
            if (bus.tx_valid && bus.tx_ready) begin
                check("b2b_accept_in_idle", busy, 0);
                n_acc++;
            end
            if (bus.rx_valid) begin
                got[n_rx] = bus.rx_data;
                $display("b2b rx word %0d = %02h", n_rx, bus.rx_data);
                n_rx++;
            end
            tick();
            if (n_acc == 1) bus.tx_data  = 8'h00;
            if (n_acc == 2) bus.tx_valid = 1'b0;
        end
        bus.rx_ready = 1'b0;
        bus.tx_valid = 1'b0;
        check("b2b_accepts", n_acc, 2);
        check("b2b_words",   n_rx,  2);
        check("b2b_first",   got[0], 8'hFF);
        check("b2b_second",  got[1], 8'h00);

        // clear at SHIFT cycle 6 of 0x3C
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h3C;
        tick();
        bus.tx_valid = 1'b0;
        repeat (6) tick();
        check("clr_pre_shift_en", shift_en, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_shift_en", shift_en,     0);
        check("clr_rx_valid", bus.rx_valid, 0);
        check("clr_tx_ready", bus.tx_ready, 1);
        check("clr_busy",     busy,         0);
        $display("tx 3c aborted by clear");
        send_word(8'h81, -1, sseq, en, lat);
        check("post_clr_rx_data", bus.rx_data, 8'h81);
        check("post_clr_latency", lat,         13);
        take_word();

        // W=1, DEPTH=1: 2 shift cycles, rx_valid in the 3rd cycle
        bus1.tx_valid = 1'b1;
        bus1.tx_data  = 1'b1;
        tick();
        bus1.tx_valid = 1'b0;
        bus1.tx_data  = 1'b0;
        en  = 0;
        lat = 1;
        while (!bus1.rx_valid && lat < 20) begin
            en += int'(shift_en1);
            tick();
            lat++;
        end
        $display("w1 tx 1 -> rx %0d (rx_valid in cycle %0d)", bus1.rx_data, lat);
        check("w1_shift_en", en,           2);
        check("w1_latency",  lat,          3);
        check("w1_rx_data",  bus1.rx_data, 1);
        bus1.rx_ready = 1'b1;
        tick();
        bus1.rx_ready = 1'b0;
        check("w1_tx_ready", bus1.tx_ready, 1);

`ifdef SHIFT_REGISTER_SEQUENCER_CHECK_EN
        // Stage 2 loads ~stage1 at the edge ending shift cycle 5; stage 1 then
        // holds bit 3, so bit 3 arrives inverted: 0x5A ^ 0x08 = 0x52.
        send_word(8'h5A, 5, sseq, en, lat);
        check("flt_rx_data", bus.rx_data, 8'h52);
        check("flt_err",     err,         1);
        take_word();
        check("flt_err_clr", err,         0);
        send_word(8'h5A, -1, sseq, en, lat);
        check("cln_rx_data", bus.rx_data, 8'h5A);
        check("cln_err",     err,         0);
        take_word();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
